// File: rtl/soc_pkg.sv
// +--------------------------------------------------------------------+
// | soc_pkg : shared sizes, FSM encoding and memory preload for soc_top |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package soc_pkg;

  localparam int DW        = 32;
  localparam int MEM_DEPTH = 64;
  localparam int TAPS      = 3;
  localparam int NSAMP     = 5;
  localparam int X_BASE    = 0;
  localparam int H_BASE    = 16;
  localparam int Y_BASE    = 32;

  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int NW  = $clog2(NSAMP);
  localparam int KW  = $clog2(TAPS);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

  localparam logic [DW-1:0] X_INIT [NSAMP] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
  localparam logic [DW-1:0] H_INIT [TAPS]  = '{32'd1, 32'd2, 32'd3};

  // Word loaded into a given address while reset is held.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] addr);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < NSAMP; j++) begin
      if (addr == AW'(X_BASE + j)) w = X_INIT[NW'(j)];
    end
    for (int j = 0; j < TAPS; j++) begin
      if (addr == AW'(H_BASE + j)) w = H_INIT[KW'(j)];
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// +--------------------------------------------------------------------+
// | data_memory : 2 async read ports, 1 sync write port, reset preload  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module data_memory
  import soc_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] dataMem [0:MEM_DEPTH-1];

  // Reset restores the full image every edge, so an aborted run leaves no residue.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        dataMem[AW'(i)] <= init_word(AW'(i));
      end
    end else if (we_i) begin
      dataMem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = dataMem[raddr_a_i];
  assign rdata_b_o = dataMem[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/fir_cpu.sv
// +--------------------------------------------------------------------+
// | fir_cpu : 3-tap FIR engine (FSM, counters, accumulator, data memory)|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module fir_cpu
  import soc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni
);

  fir_state_e           state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [DW-1:0] acc_q, acc_d;
  logic                 fir_done, fir_done_d;

  logic [AW-1:0]        x_addr, h_addr, y_addr;
  logic [DW-1:0]        x_word, h_word;
  logic signed [DW-1:0] prod, term;
  logic                 we;

  // x[n-k] wraps for n<k; the term is masked out so the stray read is harmless.
  assign x_addr = AW'(X_BASE) + AW'(n_q) - AW'(k_q);
  assign h_addr = AW'(H_BASE) + AW'(k_q);
  assign y_addr = AW'(Y_BASE) + AW'(n_q);

  assign prod = $signed(h_word) * $signed(x_word);
  assign term = (NW'(k_q) <= n_q) ? prod : '0;

  data_memory dataMemoryDut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .raddr_a_i (x_addr),
    .rdata_a_o (x_word),
    .raddr_b_i (h_addr),
    .rdata_b_o (h_word),
    .we_i      (we),
    .waddr_i   (y_addr),
    .wdata_i   (acc_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= CLEAR;
      n_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      fir_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      fir_done <= fir_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    acc_d      = acc_q;
    fir_done_d = fir_done;
    we         = 1'b0;
    case (state_q)
      CLEAR: begin
        acc_d   = '0;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + term;
        if (k_q == KW'(TAPS - 1)) begin
          state_d = STORE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      STORE: begin
        we = 1'b1;
        if (n_q == NW'(NSAMP - 1)) begin
          state_d    = DONE;
          fir_done_d = 1'b1;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = CLEAR;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/soc_top.sv
// +--------------------------------------------------------------------+
// | soc_top : FIR demonstrator top, wires clock/reset into the engine   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module soc_top (
  input  logic clock,
  input  logic reset
);

  fir_cpu cpu (
    .clk_i  (clock),
    .rst_ni (reset)
  );

endmodule

`default_nettype wire

// File: tb/tb_soc_top.sv
// +--------------------------------------------------------------------+
// | tb_soc_top : scoreboard bench for the FIR demonstrator              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_soc_top;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  soc_top dut (
    .clock (clock),
    .reset (reset)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q [$];
  wr_t  mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Hand-computed y: 1, 1*2+2*1, 3+4+3, 4+6+6, 5+8+9.
  function automatic logic [31:0] y_exp(input int n);
    case (n)
      0:       return 32'd1;
      1:       return 32'd4;
      2:       return 32'd10;
      3:       return 32'd16;
      4:       return 32'd22;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int a, input bit with_y);
    if (a >= 0 && a <= 4)                 return 32'(a + 1);
    if (a >= 16 && a <= 18)               return 32'(a - 15);
    if (with_y && a >= 32 && a <= 36)     return y_exp(a - 32);
    return 32'd0;
  endfunction

  function automatic logic [31:0] mem_rd(input int a);
    return dut.cpu.dataMemoryDut.dataMem[a];
  endfunction

  task automatic check_mem(input string tag, input bit with_y);
    for (int a = 0; a < 64; a++) begin
      chk($sformatf("%s_mem[%0d]", tag, a), mem_rd(a), model_word(a, with_y));
    end
  endtask

  task automatic push_writes(input int count);
    for (int n = 0; n < count; n++) begin
      exp_q.push_back('{addr: 32 + n, data: y_exp(n)});
    end
  endtask

  // Every write the engine presents is matched against the expected stream.
  always @(negedge clock) begin
    if (reset === 1'b1 && dut.cpu.dataMemoryDut.we_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                 dut.cpu.dataMemoryDut.waddr_i, dut.cpu.dataMemoryDut.wdata_i);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(dut.cpu.dataMemoryDut.waddr_i), 32'(mon_e.addr));
        chk("wr_data", dut.cpu.dataMemoryDut.wdata_i, mon_e.data);
      end
    end
  end

  task automatic full_run(input string tag);
    push_writes(5);
    reset = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clock);
      #1;
      if (e == 5)  chk({tag, "_y0_at5"},   mem_rd(32), 32'd1);
      if (e == 10) chk({tag, "_y1_at10"},  mem_rd(33), 32'd4);
      if (e == 14) chk({tag, "_y2_at14"},  mem_rd(34), 32'd0);
      if (e == 24) chk({tag, "_done_at24"}, 32'(dut.cpu.fir_done), 32'd0);
    end
    chk({tag, "_done_at25"}, 32'(dut.cpu.fir_done), 32'd1);
    check_mem({tag, "_final"}, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_done", 32'(dut.cpu.fir_done), 32'd0);
    check_mem("rst", 1'b0);

    full_run("run1");

    repeat (20) @(posedge clock);
    #1;
    chk("idle_done", 32'(dut.cpu.fir_done), 32'd1);
    check_mem("idle", 1'b1);
    chk("idle_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort a run after edge 12 (y[0], y[1] already written).
    reset = 1'b0;
    @(posedge clock);
    #1;
    push_writes(2);
    reset = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    chk("mid_y1", mem_rd(33), 32'd4);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_done", 32'(dut.cpu.fir_done), 32'd0);
    for (int a = 32; a <= 36; a++) begin
      chk($sformatf("abort_mem[%0d]", a), mem_rd(a), 32'd0);
    end
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    full_run("run2");
    @(posedge clock);
    #1;
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
